// File: rtl/mem_access_unit_if.sv
// Bus bundle between the control unit / RAM side and the memory access unit.
// The slave modport is the unit itself; the master modport is whatever drives it.
interface mem_access_unit_if #(
  parameter int ADDR_W = 9
);
  logic [31:0]       BusMuxOut;
  logic              MARin;
  logic              MDRin;
  logic              MD_Read;
  logic              ReadRAM;
  logic              WriteRAM;
  logic              ErrClr;
  logic [31:0]       MemDataIn;
  logic              MemReady;
  logic [ADDR_W-1:0] MemAddr;
  logic [31:0]       MemDataOut;
  logic              MemRd;
  logic              MemWr;
  logic [31:0]       MDRdata;
  logic              MemBusy;
  logic              MemDone;
  logic              MemErr;

  modport master (
    output BusMuxOut, MARin, MDRin, MD_Read, ReadRAM, WriteRAM, ErrClr,
           MemDataIn, MemReady,
    input  MemAddr, MemDataOut, MemRd, MemWr, MDRdata, MemBusy, MemDone, MemErr
  );

  modport slave (
    input  BusMuxOut, MARin, MDRin, MD_Read, ReadRAM, WriteRAM, ErrClr,
           MemDataIn, MemReady,
    output MemAddr, MemDataOut, MemRd, MemWr, MDRdata, MemBusy, MemDone, MemErr
  );
endinterface

// File: rtl/mem_access_unit.sv
// MAR/MDR pair plus a small handshake FSM that runs one RAM read or write at a
// time, with a bounded wait for MemReady and a sticky error flag.
module mem_access_unit #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input logic              Clock,
  input logic              Reset,
  mem_access_unit_if.slave bus
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] mar_q;
  logic [31:0]       mdr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              rd_q;
  logic              wr_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic              waiting;
  logic              timeout;
  logic              req_any;
  logic              req_clash;
  logic              err_d;
  logic [31:0]       mdr_load_d;

  always_comb begin
    waiting    = (state_q == RD_WAIT) || (state_q == WR_WAIT);
    timeout    = waiting && !bus.MemReady && (cnt_q == CNT_LAST);
    req_any    = bus.ReadRAM || bus.WriteRAM;
    req_clash  = bus.ReadRAM && bus.WriteRAM;
    mdr_load_d = bus.MD_Read ? bus.MemDataIn : bus.BusMuxOut;
    // Any new error outranks a clear arriving in the same cycle.
    err_d = err_q;
    if (bus.ErrClr)
      err_d = 1'b0;
    if (timeout || ((state_q == IDLE) ? req_clash : req_any))
      err_d = 1'b1;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= err_d;

      // Address and data registers are frozen while an access is in flight.
      if (!waiting) begin
        if (bus.MARin)
          mar_q <= bus.BusMuxOut[ADDR_W-1:0];
        if (bus.MDRin)
          mdr_q <= mdr_load_d;
      end

      case (state_q)
        IDLE: begin
          if (bus.ReadRAM && !bus.WriteRAM) begin
            state_q <= RD_WAIT;
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end else if (bus.WriteRAM && !bus.ReadRAM) begin
            state_q <= WR_WAIT;
            wr_q    <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end

        RD_WAIT, WR_WAIT: begin
          if (bus.MemReady || timeout) begin
            if (bus.MemReady && (state_q == RD_WAIT))
              mdr_q <= bus.MemDataIn;
            state_q <= DONE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.MemAddr    = mar_q;
  assign bus.MemDataOut = mdr_q;
  assign bus.MDRdata    = mdr_q;
  assign bus.MemRd      = rd_q;
  assign bus.MemWr      = wr_q;
  assign bus.MemBusy    = busy_q;
  assign bus.MemDone    = done_q;
  assign bus.MemErr     = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: read, write, timeout, request clashes,
// frozen MAR during an access and asynchronous reset in the middle of a read.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rd_cyc   = 0;
  int   wr_cyc   = 0;
  int   done_cyc = 0;
  int   snap_rd;
  int   snap_wr;
  int   snap_done;

  mem_access_unit_if #(.ADDR_W(9)) bus ();

  mem_access_unit #(.ADDR_W(9), .TIMEOUT(15)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Strobe activity is tallied mid-cycle so whole-transaction counts can be checked.
  always @(negedge clk) begin
    if (bus.MemRd)   rd_cyc++;
    if (bus.MemWr)   wr_cyc++;
    if (bus.MemDone) done_cyc++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    snap_rd   = rd_cyc;
    snap_wr   = wr_cyc;
    snap_done = done_cyc;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.BusMuxOut = '0;
    bus.MARin     = 1'b0;
    bus.MDRin     = 1'b0;
    bus.MD_Read   = 1'b0;
    bus.ReadRAM   = 1'b0;
    bus.WriteRAM  = 1'b0;
    bus.ErrClr    = 1'b0;
    bus.MemDataIn = '0;
    bus.MemReady  = 1'b0;

    // Reset state
    #2;
    check_eq("rst_addr", 32'(bus.MemAddr), 32'h0);
    check_eq("rst_mdr",  bus.MDRdata, 32'h0);
    check_eq("rst_busy", 32'(bus.MemBusy), 32'h0);
    check_eq("rst_rdwr", 32'({bus.MemRd, bus.MemWr}), 32'h0);
    check_eq("rst_done_err", 32'({bus.MemDone, bus.MemErr}), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    $display("txn reset released");

    // Read from 0x054, MemReady in the third wait cycle
    bus.MARin = 1'b1;
    bus.BusMuxOut = 32'h0000_0054;
    tick();
    check_eq("mar_load", 32'(bus.MemAddr), 32'h054);
    bus.MARin = 1'b0;
    bus.ReadRAM = 1'b1;
    snap();
    tick();
    bus.ReadRAM = 1'b0;
    check_eq("rd_w1_memrd", 32'(bus.MemRd), 32'h1);
    check_eq("rd_w1_busy", 32'(bus.MemBusy), 32'h1);
    tick();
    tick();
    bus.MemReady = 1'b1;
    bus.MemDataIn = 32'hDEAD_BEEF;
    check_eq("rd_w3_done", 32'(bus.MemDone), 32'h0);
    tick();
    bus.MemReady = 1'b0;
    check_eq("rd_done", 32'(bus.MemDone), 32'h1);
    check_eq("rd_done_memrd", 32'(bus.MemRd), 32'h0);
    check_eq("rd_mdr", bus.MDRdata, 32'hDEAD_BEEF);
    tick();
    check_eq("rd_idle_busy", 32'(bus.MemBusy), 32'h0);
    check_eq("rd_idle_done", 32'(bus.MemDone), 32'h0);
    check_eq("rd_rd_cycles", 32'(rd_cyc - snap_rd), 32'd3);
    check_eq("rd_done_pulses", 32'(done_cyc - snap_done), 32'd1);
    $display("txn read addr=0x%03h data=0x%08h", bus.MemAddr, bus.MDRdata);

    // Write 0x12345678 loaded from the bus, MemReady in the first wait cycle
    bus.MDRin = 1'b1;
    bus.MD_Read = 1'b0;
    bus.BusMuxOut = 32'h1234_5678;
    tick();
    check_eq("mdr_bus_load", bus.MDRdata, 32'h1234_5678);
    bus.MDRin = 1'b0;
    bus.WriteRAM = 1'b1;
    snap();
    tick();
    bus.WriteRAM = 1'b0;
    bus.MemReady = 1'b1;
    check_eq("wr_memwr", 32'(bus.MemWr), 32'h1);
    check_eq("wr_memrd", 32'(bus.MemRd), 32'h0);
    check_eq("wr_dataout", bus.MemDataOut, 32'h1234_5678);
    tick();
    bus.MemReady = 1'b0;
    check_eq("wr_done", 32'(bus.MemDone), 32'h1);
    check_eq("wr_mdr_kept", bus.MDRdata, 32'h1234_5678);
    tick();
    check_eq("wr_wr_cycles", 32'(wr_cyc - snap_wr), 32'd1);
    check_eq("wr_done_pulses", 32'(done_cyc - snap_done), 32'd1);
    $display("txn write addr=0x%03h data=0x%08h", bus.MemAddr, bus.MemDataOut);

    // MDR loaded from RAM data in IDLE, then a stray MemReady in IDLE
    bus.MDRin = 1'b1;
    bus.MD_Read = 1'b1;
    bus.MemDataIn = 32'hA5A5_0F0F;
    tick();
    bus.MDRin = 1'b0;
    bus.MD_Read = 1'b0;
    check_eq("mdr_ram_load", bus.MDRdata, 32'hA5A5_0F0F);
    bus.MemReady = 1'b1;
    bus.MemDataIn = 32'h1111_1111;
    tick();
    bus.MemReady = 1'b0;
    check_eq("idle_ready_busy", 32'(bus.MemBusy), 32'h0);
    check_eq("idle_ready_mdr", bus.MDRdata, 32'hA5A5_0F0F);
    $display("txn mdr load=0x%08h", bus.MDRdata);

    // Read with no MemReady: aborts after 15 wait cycles
    bus.ReadRAM = 1'b1;
    snap();
    tick();
    bus.ReadRAM = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    check_eq("to_w15_done", 32'(bus.MemDone), 32'h0);
    check_eq("to_w15_err", 32'(bus.MemErr), 32'h0);
    tick();
    check_eq("to_done", 32'(bus.MemDone), 32'h1);
    check_eq("to_err", 32'(bus.MemErr), 32'h1);
    check_eq("to_mdr", bus.MDRdata, 32'hA5A5_0F0F);
    tick();
    check_eq("to_rd_cycles", 32'(rd_cyc - snap_rd), 32'd15);
    // Error clear loses to a simultaneous clash, then clears on its own
    bus.ErrClr = 1'b1;
    bus.ReadRAM = 1'b1;
    bus.WriteRAM = 1'b1;
    tick();
    bus.ReadRAM = 1'b0;
    bus.WriteRAM = 1'b0;
    check_eq("clr_vs_err", 32'(bus.MemErr), 32'h1);
    tick();
    bus.ErrClr = 1'b0;
    check_eq("err_clr", 32'(bus.MemErr), 32'h0);
    $display("txn timeout read wait_cycles=%0d", rd_cyc - snap_rd);

    // Read and write in the same cycle
    bus.ReadRAM = 1'b1;
    bus.WriteRAM = 1'b1;
    tick();
    bus.ReadRAM = 1'b0;
    bus.WriteRAM = 1'b0;
    check_eq("clash_rdwr", 32'({bus.MemRd, bus.MemWr}), 32'h0);
    check_eq("clash_busy", 32'(bus.MemBusy), 32'h0);
    check_eq("clash_err", 32'(bus.MemErr), 32'h1);
    bus.ErrClr = 1'b1;
    tick();
    bus.ErrClr = 1'b0;
    check_eq("clash_clr", 32'(bus.MemErr), 32'h0);
    $display("txn clash rejected");

    // Second ReadRAM and a MARin during RD_WAIT are both ignored
    bus.ReadRAM = 1'b1;
    snap();
    tick();
    bus.MARin = 1'b1;
    bus.BusMuxOut = 32'h0000_01FF;
    tick();
    bus.ReadRAM = 1'b0;
    bus.MARin = 1'b0;
    check_eq("busy_req_err", 32'(bus.MemErr), 32'h1);
    check_eq("busy_req_busy", 32'(bus.MemBusy), 32'h1);
    check_eq("busy_mar_frozen", 32'(bus.MemAddr), 32'h054);
    bus.MemReady = 1'b1;
    bus.MemDataIn = 32'h0BAD_F00D;
    tick();
    bus.MemReady = 1'b0;
    check_eq("busy_rd_mdr", bus.MDRdata, 32'h0BAD_F00D);
    tick();
    tick();
    check_eq("busy_done_pulses", 32'(done_cyc - snap_done), 32'd1);
    bus.ErrClr = 1'b1;
    tick();
    bus.ErrClr = 1'b0;
    $display("txn read with overlapping request data=0x%08h", bus.MDRdata);

    // Asynchronous reset in the middle of a read
    bus.ReadRAM = 1'b1;
    snap();
    tick();
    bus.ReadRAM = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_memrd", 32'(bus.MemRd), 32'h0);
    check_eq("arst_busy", 32'(bus.MemBusy), 32'h0);
    check_eq("arst_mdr", bus.MDRdata, 32'h0);
    tick();
    rst = 1'b0;
    bus.ReadRAM = 1'b1;
    bus.MARin = 1'b1;
    bus.BusMuxOut = 32'h0000_00AB;
    tick();
    bus.ReadRAM = 1'b0;
    bus.MARin = 1'b0;
    check_eq("arst_no_done", 32'(done_cyc - snap_done), 32'd0);
    check_eq("post_rst_memrd", 32'(bus.MemRd), 32'h1);
    check_eq("post_rst_addr", 32'(bus.MemAddr), 32'h0AB);
    bus.MemReady = 1'b1;
    bus.MemDataIn = 32'hCAFE_F00D;
    tick();
    bus.MemReady = 1'b0;
    check_eq("post_rst_done", 32'(bus.MemDone), 32'h1);
    check_eq("post_rst_mdr", bus.MDRdata, 32'hCAFE_F00D);
    tick();
    check_eq("post_rst_idle", 32'(bus.MemBusy), 32'h0);
    $display("txn read after reset addr=0x%03h data=0x%08h", bus.MemAddr, bus.MDRdata);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ADDR_W, default 9, width of the memory address (MAR low bits driven to RAM).
REQ-002 Parameter TIMEOUT, default 15, maximum cycles to wait for MemReady before aborting.
REQ-003 Clock  input  1  rising-edge clock for all state.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 BusMuxOut  input  32  datapath bus value.
REQ-006 MARin  input  1  load MAR from BusMuxOut.
REQ-007 MDRin  input  1  load MDR; source chosen by MD_Read.
REQ-008 MD_Read  input  1  MDR source select: 1 = RAM read data, 0 = BusMuxOut.
REQ-009 ReadRAM  input  1  single-cycle read request from control unit.
REQ-010 WriteRAM  input  1  single-cycle write request from control unit.
REQ-011 ErrClr  input  1  clears sticky MemErr.
REQ-012 MemDataIn  input  32  RAM read data, valid in the MemReady cycle.
REQ-013 MemReady  input  1  RAM acknowledge.
REQ-014 MemAddr  output  ADDR_W  MAR[ADDR_W-1:0].
REQ-015 MemDataOut  output  32  MDR contents to RAM.
REQ-016 MemRd, MemWr  output  1 each  RAM strobes.
REQ-017 MDRdata  output  32  MDR contents to bus mux.
REQ-018 MemBusy  output  1  high in any state other than IDLE.
REQ-019 MemDone  output  1  one-cycle completion pulse.
REQ-020 MemErr  output  1  sticky error flag.

Function
REQ-021 FSM states: IDLE, RD_WAIT, WR_WAIT, DONE; the unit SHALL remain in IDLE until a legal request arrives.
REQ-022 IDLE + ReadRAM=1, WriteRAM=0 -> RD_WAIT next cycle; MemRd=1 throughout RD_WAIT.
REQ-023 IDLE + WriteRAM=1, ReadRAM=0 -> WR_WAIT next cycle; MemWr=1 throughout WR_WAIT; MemDataOut = MDR at request time.
REQ-024 IDLE + ReadRAM=1 and WriteRAM=1 same cycle -> no access, stay IDLE, set MemErr.
REQ-025 RD_WAIT + MemReady=1 -> MDR <= MemDataIn on that edge, go DONE.
REQ-026 WR_WAIT + MemReady=1 -> go DONE; MDR unchanged.
REQ-027 Wait counter cleared on entry to RD_WAIT/WR_WAIT, +1 per cycle without MemReady; reaching TIMEOUT -> go DONE, set MemErr, MDR unchanged.
REQ-028 DONE lasts exactly one cycle with MemDone=1, then IDLE; minimum request-to-MemDone latency 2 cycles (MemReady in first wait cycle).
REQ-029 MARin in IDLE or DONE: MAR <= BusMuxOut; MARin in RD_WAIT/WR_WAIT ignored (address stable during access).
REQ-030 MDRin in IDLE or DONE: MDR <= MD_Read ? MemDataIn : BusMuxOut; MDRin in RD_WAIT/WR_WAIT ignored.
REQ-031 ReadRAM or WriteRAM while not IDLE: ignored, MemErr set; current access continues.
REQ-032 ErrClr=1 clears MemErr next edge; a simultaneous error condition wins (MemErr stays 1).
REQ-033 MemRd and MemWr SHALL never be high in the same cycle.
REQ-034 MemReady in IDLE or DONE is ignored.

Reset
REQ-035 Reset=1 forces immediately (no clock): state IDLE, MAR=0, MDR=0, counter=0, MemErr=0, MemRd=MemWr=MemBusy=MemDone=0.
REQ-036 Reset mid-access aborts the access with no MDR update and no MemDone pulse; first request accepted on the first edge after Reset falls.

Verification
REQ-037 MARin with BusMuxOut=0x0000_0054, ReadRAM pulse, MemReady 3 cycles later with MemDataIn=0xDEAD_BEEF -> MemAddr=0x054, MemRd high 3 cycles, MDRdata=0xDEAD_BEEF, single MemDone pulse.
REQ-038 MDRin with MD_Read=0, BusMuxOut=0x1234_5678, WriteRAM pulse, MemReady next cycle -> MemWr 1 cycle, MemDataOut=0x1234_5678, MemDone 2 cycles after request.
REQ-039 ReadRAM with MemReady held 0 -> MemDone after TIMEOUT (15) wait cycles, MemErr=1, MDR unchanged; ErrClr pulse -> MemErr=0.
REQ-040 ReadRAM and WriteRAM same cycle -> MemRd=MemWr=0, MemBusy=0, MemErr=1; second ReadRAM during RD_WAIT -> MemErr=1, only one MemDone.
REQ-041 Reset asserted in RD_WAIT between clock edges -> MemRd=0, MemBusy=0 immediately, MDR=0, no MemDone; new read after release completes normally.
